// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter.
//   arb_state_t            - arbiter FSM states
//   BAUD_*                 - baud codes understood by the transmitter
//   DEFAULT_*              - default gap / watchdog settings
//   onehot8()              - index to one-hot helper (up to 8 requesters)
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam logic [3:0] BAUD_9600  = 4'd0;
    localparam logic [3:0] BAUD_19200 = 4'd1;
    localparam logic [3:0] BAUD_38400 = 4'd2;
    localparam logic [3:0] BAUD_57600 = 4'd3;

    localparam int DEFAULT_GAP_CYCLES     = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector.
//   req    in  NUM_REQ  request levels
//   rr_ptr in  IDW      first index to consider (priority start)
//   valid  out 1        at least one request is set
//   w      out IDW      first set request at or after rr_ptr, wrapping
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               valid,
    output logic [IDW-1:0]     w
);

    int idx;

    always_comb begin
        valid = 1'b0;
        w     = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[idx]) begin
                valid = 1'b1;
                w     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
// Round-robin grant, one-cycle send_en, baud held for the whole frame,
// completion on tx_done, then a forced idle gap before the next grant.
//   mclk, rst          clock, asynchronous active-high reset
//   req, req_data      request levels and per-requester bytes [8i+7:8i]
//   baud_cfg           baud code, captured at grant
//   grant_ack          one-hot pulse: byte accepted
//   frame_done         one-hot pulse: frame completed
//   tx_send_en, tx_data_byte, tx_baud_set, tx_done   transmitter pins
//   busy, grant_id     status: not IDLE, index of current/last winner
//   timeout_err        pulse on WAIT watchdog expiry
// Optional feature: define UART_ARB_TIMEOUT_EN to build the WAIT watchdog;
// otherwise WAIT exits only on tx_done and timeout_err is tied low.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       mclk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [3:0]                 baud_cfg,
    output logic [NUM_REQ-1:0]         grant_ack,
    output logic [NUM_REQ-1:0]         frame_done,
    output logic                       tx_send_en,
    output logic [7:0]                 tx_data_byte,
    output logic [3:0]                 tx_baud_set,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int         IDW      = $clog2(NUM_REQ);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    arb_state_t           state, state_nxt;
    logic [IDW-1:0]       rr_ptr, rr_nxt;
    logic [IDW-1:0]       gid_nxt;
    logic [7:0]           data_nxt;
    logic [3:0]           baud_nxt;
    logic                 send_nxt;
    logic [NUM_REQ-1:0]   ack_nxt, fdone_nxt;
    logic [7:0]           gap_cnt, gap_nxt;
    logic                 pick_vld;
    logic [IDW-1:0]       pick_w;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] wd_cnt, wd_nxt;
    logic        tout_nxt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .w      (pick_w)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        gid_nxt   = grant_id;
        data_nxt  = tx_data_byte;
        baud_nxt  = tx_baud_set;
        send_nxt  = 1'b0;
        ack_nxt   = '0;
        fdone_nxt = '0;
        gap_nxt   = gap_cnt;
`ifdef UART_ARB_TIMEOUT_EN
        wd_nxt    = wd_cnt;
        tout_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = SEND;
                    gid_nxt   = pick_w;
                    data_nxt  = req_data[8*pick_w +: 8];
                    baud_nxt  = baud_cfg;
                    rr_nxt    = (pick_w == IDW'(NUM_REQ-1)) ? '0 : pick_w + 1'b1;
                    send_nxt  = 1'b1;
                    ack_nxt   = NUM_REQ'(onehot8(3'(pick_w)));
                end
            end
            SEND: begin
                state_nxt = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                wd_nxt    = '0;
`endif
            end
            WAIT: begin
                // tx_done takes priority over a simultaneous watchdog expiry
                if (tx_done) begin
                    fdone_nxt = NUM_REQ'(onehot8(3'(grant_id)));
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_cnt + 16'd1 == TIMEOUT_LIM) begin
                    tout_nxt  = 1'b1;
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end else begin
                    wd_nxt    = wd_cnt + 16'd1;
                end
`endif
            end
            GAP: begin
                // a load of 0 or 1 both give a single GAP cycle
                if (gap_cnt <= 8'd1) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt   = gap_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            tx_data_byte <= '0;
            tx_baud_set  <= '0;
            tx_send_en   <= 1'b0;
            grant_ack    <= '0;
            frame_done   <= '0;
            gap_cnt      <= '0;
            busy         <= 1'b0;
        end else begin
            rr_ptr       <= rr_nxt;
            grant_id     <= gid_nxt;
            tx_data_byte <= data_nxt;
            tx_baud_set  <= baud_nxt;
            tx_send_en   <= send_nxt;
            grant_ack    <= ack_nxt;
            frame_done   <= fdone_nxt;
            gap_cnt      <= gap_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt      <= wd_nxt;
            timeout_err <= tout_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
// (NUM_REQ=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20).
module tb_uart_tx_arbiter;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  baud_cfg = '0;
    logic [3:0]  grant_ack;
    logic [3:0]  frame_done;
    logic        tx_send_en;
    logic [7:0]  tx_data_byte;
    logic [3:0]  tx_baud_set;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20)) dut (
        .mclk         (mclk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .baud_cfg     (baud_cfg),
        .grant_ack    (grant_ack),
        .frame_done   (frame_done),
        .tx_send_en   (tx_send_en),
        .tx_data_byte (tx_data_byte),
        .tx_baud_set  (tx_baud_set),
        .tx_done      (tx_done),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_send(input string name);
        int n = 0;
        while (!tx_send_en && n < 30) begin
            tick();
            n++;
        end
        vec_cnt++;
        if (tx_send_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_wait_send: tx_send_en=%b after %0d cycles, required 1", name, tx_send_en, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_wait_idle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vec_cnt++;
        if ({tx_send_en, grant_ack, frame_done, timeout_err} !== 10'd0) begin
            err_cnt++;
            $display("FAIL reset_pulses: send=%b ack=%b fdone=%b tout=%b, required all 0",
                     tx_send_en, grant_ack, frame_done, timeout_err);
        end
        vec_cnt++;
        if ({tx_data_byte, tx_baud_set, grant_id, busy} !== 15'd0) begin
            err_cnt++;
            $display("FAIL reset_regs: data=%h baud=%h gid=%0d busy=%b, required all 0",
                     tx_data_byte, tx_baud_set, grant_id, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_data = 32'h00A5_0000;
        baud_cfg = 4'd1;
        req      = 4'b0100;
        tick();
        vec_cnt++;
        if (tx_send_en !== 1'b1 || grant_ack !== 4'b0100) begin
            err_cnt++;
            $display("FAIL single_grant: send=%b ack=%b, required 1 0100", tx_send_en, grant_ack);
        end
        vec_cnt++;
        if (tx_data_byte !== 8'hA5 || tx_baud_set !== 4'd1 || grant_id !== 2'd2 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_capture: data=%h baud=%0d gid=%0d busy=%b, required a5 1 2 1",
                     tx_data_byte, tx_baud_set, grant_id, busy);
        end
        req = 4'b0000;
        tick();
        vec_cnt++;
        if (tx_send_en !== 1'b0 || grant_ack !== 4'b0000) begin
            err_cnt++;
            $display("FAIL single_pulse_len: send=%b ack=%b, required 0 0000", tx_send_en, grant_ack);
        end
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vec_cnt++;
        if (frame_done !== 4'b0100 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_frame_done: fdone=%b busy=%b, required 0100 1", frame_done, busy);
        end
        tick();
        vec_cnt++;
        if (frame_done !== 4'b0000 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_gap1: fdone=%b busy=%b, required 0000 1", frame_done, busy);
        end
        tick();
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_gap_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        tick();
        req_data = 32'h1312_1110;
        baud_cfg = 4'd2;
        req      = 4'b1111;
        rst      = 1'b0;
        for (int f = 0; f < 5; f++) begin
            wait_send("rr");
            vec_cnt++;
            if (grant_id !== exp_id[f] || grant_ack !== (4'b0001 << exp_id[f])) begin
                err_cnt++;
                $display("FAIL rr_order_%0d: gid=%0d ack=%b, required %0d", f, grant_id, grant_ack, exp_id[f]);
            end
            vec_cnt++;
            if (tx_data_byte !== (8'h10 + 8'(exp_id[f]))) begin
                err_cnt++;
                $display("FAIL rr_data_%0d: data=%h, required %h", f, tx_data_byte, 8'h10 + 8'(exp_id[f]));
            end
            tick();
            vec_cnt++;
            if (tx_send_en !== 1'b0) begin
                err_cnt++;
                $display("FAIL rr_single_send_%0d: send=%b, required 0", f, tx_send_en);
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            vec_cnt++;
            if (frame_done !== (4'b0001 << exp_id[f])) begin
                err_cnt++;
                $display("FAIL rr_fdone_%0d: fdone=%b, required %b", f, frame_done, 4'b0001 << exp_id[f]);
            end
        end
        req = 4'b0000;
        wait_idle("rr");
    endtask

    task automatic test_baud_hold();
        req_data = 32'h0000_3C5A;
        baud_cfg = 4'd1;
        req      = 4'b0010;
        wait_send("baud");
        req = 4'b0000;
        tick();
        baud_cfg = 4'd3;
        tick();
        tick();
        vec_cnt++;
        if (tx_baud_set !== 4'd1) begin
            err_cnt++;
            $display("FAIL baud_hold_wait: baud=%0d, required 1", tx_baud_set);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vec_cnt++;
        if (tx_baud_set !== 4'd1 || tx_data_byte !== 8'h3C) begin
            err_cnt++;
            $display("FAIL baud_hold_gap: baud=%0d data=%h, required 1 3c", tx_baud_set, tx_data_byte);
        end
        wait_idle("baud");
        req = 4'b0001;
        wait_send("baud2");
        req = 4'b0000;
        vec_cnt++;
        if (tx_baud_set !== 4'd3 || tx_data_byte !== 8'h5A) begin
            err_cnt++;
            $display("FAIL baud_new_grant: baud=%0d data=%h, required 3 5a", tx_baud_set, tx_data_byte);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle("baud2");
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        req = 4'b0100;
        wait_send("tout");
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (timeout_err !== 1'b0 || frame_done !== 4'b0000) early++;
        end
        vec_cnt++;
        if (early != 0) begin
            err_cnt++;
            $display("FAIL tout_early: %0d cycles with pulse before expiry, required 0", early);
        end
        tick();
        vec_cnt++;
        if (timeout_err !== 1'b1 || frame_done !== 4'b0000 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL tout_expiry: tout=%b fdone=%b busy=%b, required 1 0000 1", timeout_err, frame_done, busy);
        end
        tick();
        vec_cnt++;
        if (timeout_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL tout_pulse_len: tout=%b, required 0", timeout_err);
        end
        wait_send("tout_next");
        req = 4'b0000;
        vec_cnt++;
        if (grant_id !== 2'd3) begin
            err_cnt++;
            $display("FAIL tout_next_grant: gid=%0d, required 3", grant_id);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle("tout");
    endtask

    task automatic test_tie();
        req = 4'b0001;
        wait_send("tie");
        req = 4'b0000;
        for (int i = 0; i < 20; i++) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vec_cnt++;
        if (frame_done !== 4'b0001 || timeout_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL tie_done_wins: fdone=%b tout=%b, required 0001 0", frame_done, timeout_err);
        end
        wait_idle("tie");
    endtask
`else
    task automatic test_no_timeout();
        int pulses = 0;
        req = 4'b0100;
        wait_send("notout");
        req = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (timeout_err !== 1'b0 || frame_done !== 4'b0000) pulses++;
        end
        vec_cnt++;
        if (pulses != 0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL notout_wait: stray pulses=%0d busy=%b, required 0 1", pulses, busy);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vec_cnt++;
        if (frame_done !== 4'b0100) begin
            err_cnt++;
            $display("FAIL notout_fdone: fdone=%b, required 0100", frame_done);
        end
        wait_idle("notout");
    endtask
`endif

    task automatic test_reset_mid();
        req_data = 32'h7700_6600;
        req      = 4'b0010;
        wait_send("rmid");
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        vec_cnt++;
        if ({tx_send_en, grant_ack, frame_done, timeout_err, tx_data_byte, tx_baud_set, grant_id, busy} !== 25'd0) begin
            err_cnt++;
            $display("FAIL rmid_outputs: send=%b ack=%b fdone=%b tout=%b data=%h baud=%h gid=%0d busy=%b, required all 0",
                     tx_send_en, grant_ack, frame_done, timeout_err, tx_data_byte, tx_baud_set, grant_id, busy);
        end
        rst = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vec_cnt++;
        if (frame_done !== 4'b0000 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_tx_done_ignored: fdone=%b busy=%b, required 0000 0", frame_done, busy);
        end
        req = 4'b1010;
        wait_send("rmid2");
        req = 4'b0000;
        vec_cnt++;
        if (grant_id !== 2'd1 || grant_ack !== 4'b0010 || tx_data_byte !== 8'h66) begin
            err_cnt++;
            $display("FAIL rmid_rr_restart: gid=%0d ack=%b data=%h, required 1 0010 66", grant_id, grant_ack, tx_data_byte);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle("rmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_baud_hold();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
        test_tie();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among NUM_REQ byte requesters. It grants requesters in round-robin order, loads the winner's byte with a one-cycle send_en pulse, and holds baud_set stable for the whole frame. It waits for tx_done, then enforces an inter-frame idle gap before the next grant. It sits between the client logic and the transmitter's send_en / data_byte / baud_set / tx_done pins.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- GAP_CYCLES, 2: mclk cycles of forced idle after each frame, 0..255
- TIMEOUT_CYCLES, 65535: WAIT-state watchdog limit in mclk cycles, 16-bit
- mclk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; hold high with data stable until grant_ack
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- baud_cfg  in  4  baud code, sampled at grant
- grant_ack  out  NUM_REQ  one-hot one-cycle pulse: byte accepted
- frame_done  out  NUM_REQ  one-hot one-cycle pulse: frame completed (tx_done seen)
- tx_send_en  out  1  to transmitter send_en
- tx_data_byte  out  8  to transmitter data_byte
- tx_baud_set  out  4  to transmitter baud_set
- tx_done  in  1  transmitter completion pulse
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NUM_REQ)  index of current/last winner
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- The FSM has four states: IDLE, SEND, WAIT and GAP. All outputs are registered.
- IDLE: if any req bit is high, pick winner w = first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Capture req_data[w] into tx_data_byte, baud_cfg into tx_baud_set, and w into grant_id.
  - Advance rr_ptr to (w+1) mod NUM_REQ and go to SEND.
  - If no req bit is high, stay in IDLE.
- SEND: tx_send_en=1 and grant_ack[w]=1 for exactly this one cycle. Clear the watchdog counter and go to WAIT.
- WAIT: increment the 16-bit watchdog counter each cycle.
  - tx_done=1: pulse frame_done[w] next cycle, then go to GAP.
  - Counter reaches TIMEOUT_CYCLES (watchdog built in only): pulse timeout_err, no frame_done, go to GAP.
  - tx_done and expiry in the same cycle: tx_done wins.
- GAP: load the gap counter with GAP_CYCLES, count down, return to IDLE at 0. If GAP_CYCLES=0, GAP lasts one cycle.
- tx_baud_set and tx_data_byte hold their captured values from SEND until the next grant. Baud never changes mid-frame.
- tx_done outside WAIT is ignored.
- A req withdrawn before selection is simply not granted. A req raised during SEND, WAIT or GAP waits for IDLE.
- A requester whose req stays high after grant_ack is treated as a new request. Round-robin guarantees every other pending requester is served first.

## Timing
- Reset values: tx_send_en 0, tx_data_byte 0, tx_baud_set 0, grant_ack 0, frame_done 0, busy 0, grant_id 0, timeout_err 0, rr_ptr 0, state IDLE.
- req sampled high at edge k: SEND outputs (tx_send_en, grant_ack) are high during cycle k..k+1.
- tx_done sampled at edge m: frame_done is high during cycle m..m+1, and GAP starts.
- Minimum spacing between successive tx_send_en pulses: 3 + GAP_CYCLES cycles plus the tx_done latency.
- Reset mid-frame: immediate return to reset values. The transmitter is reset by the same rst domain.

## Configuration
- UART_ARB_TIMEOUT_EN defined: WAIT watchdog, counter and timeout_err are present.
- UART_ARB_TIMEOUT_EN undefined: WAIT exits only on tx_done, and timeout_err is tied to 0.

## Structure
- Package uart_arb_pkg holds:
  - state enum (IDLE, SEND, WAIT, GAP)
  - baud codes BAUD_9600=0, BAUD_19200=1, BAUD_38400=2, BAUD_57600=3
  - default GAP/TIMEOUT constants
- Sub-module uart_rr_pick: combinational round-robin pick (req, rr_ptr → valid, w). Reusable by other shared-resource controllers.

## Test plan
- Single request: req[2]=1, data 8'hA5, baud_cfg=1 → grant_ack[2] and tx_send_en one cycle later, tx_data_byte=A5, tx_baud_set=1; tx_done pulse → frame_done[2] next cycle, busy low after 2 gap cycles.
- All four req high from reset → grants in order 0,1,2,3,0; exactly one tx_send_en per frame.
- baud_cfg changed from 1 to 3 during WAIT → tx_baud_set stays 1 until the next grant.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, tx_done never asserted → timeout_err pulses 20 cycles into WAIT, no frame_done, next requester granted after the gap.
- tx_done and watchdog expiry in the same cycle → frame_done pulses, timeout_err stays 0.
- rst asserted during WAIT → all outputs 0 next edge, and a following req[1] is granted with rr_ptr starting from 0.
